// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg : shared types and constants for the wait-state data memory
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } memfsm_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 12;

  // One spare bit so the largest wait value itself fits in the counter
  function automatic int wait_cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wait_lfsr.sv
// ----------------------------------------------------------------------------
// wait_lfsr : 16-bit Galois LFSR (taps 16,14,13,11) stepping only on enable
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module wait_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_advance,
  output logic [15:0] o_value
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (i_advance) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign o_value = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/waitstate_data_mem.sv
// ----------------------------------------------------------------------------
// waitstate_data_mem : synchronous data RAM with fixed or pseudo-random stalls
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module waitstate_data_mem
  import mem_pkg::*;
#(
  parameter int          DATA_W    = DEF_DATA_W,
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter int          DEPTH     = 4096,
  parameter int          RD_WAIT   = 2,
  parameter int          WR_WAIT   = 1,
  parameter int          RAND_MODE = 0,
  parameter int          MAX_WAIT  = 7,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] DataAddr,
  input  logic [DATA_W-1:0] DataOut,
  input  logic              WriteData,
  input  logic              ReadData,
  output logic [DATA_W-1:0] DataIn,
  output logic              DataWaitreq
);

  localparam int CNT_W = wait_cnt_w(RD_WAIT, WR_WAIT, MAX_WAIT);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (RD_WAIT < 1) begin : g_err_rd_wait
    $error("RD_WAIT must be at least 1");
  end
  if (MAX_WAIT < 1) begin : g_err_max_wait
    $error("MAX_WAIT must be at least 1");
  end
  if (longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_err_depth
    $error("DEPTH exceeds the address space");
  end
  if (LFSR_SEED == 16'h0000) begin : g_err_seed
    $error("LFSR_SEED must be nonzero");
  end

  memfsm_t           state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, wait_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q, rd_d, data_in_q, data_in_d;
  logic [IDX_W-1:0]  mem_idx;
  logic [15:0]       lfsr_val;
  logic              req, is_read, in_range, zero_wait_wr, mem_we;

  assign req      = ReadData | WriteData;
  assign is_read  = ReadData & ~WriteData;
  assign in_range = {1'b0, DataAddr} < (ADDR_W+1)'(DEPTH);
  assign mem_idx  = IDX_W'(DataAddr);

  if (RAND_MODE != 0) begin : g_rand
    // Steps once per transaction start so the stall sequence is repeatable
    wait_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk       (Clock),
      .rst       (Reset),
      .i_advance (state_q == IDLE && req),
      .o_value   (lfsr_val)
    );
  end else begin : g_fixed
    assign lfsr_val = 16'h0000;
  end

  always_comb begin
    if (RAND_MODE != 0) wait_n = CNT_W'(({16'd0, lfsr_val} % 32'(MAX_WAIT)) + 32'd1);
    else if (WriteData) wait_n = CNT_W'(WR_WAIT);
    else                wait_n = CNT_W'(RD_WAIT);
  end

  assign zero_wait_wr = (state_q == IDLE) & WriteData & (wait_n == '0);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_in_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_in_q <= data_in_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req && !zero_wait_wr) begin
          cnt_d = wait_n - CNT_W'(1);
          state_d = (wait_n > CNT_W'(1)) ? WAIT : ACK;
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    DataWaitreq = 1'b0;
    DataIn      = data_in_q;
    data_in_d   = data_in_q;
    mem_we      = 1'b0;
    if (!Reset) begin
      DataWaitreq = req & (state_q != ACK) & ~zero_wait_wr;
      mem_we      = WriteData & in_range & ((state_q == ACK) | zero_wait_wr);
      if (state_q == ACK && is_read) begin
        DataIn    = rd_q;
        data_in_d = rd_q;
      end
    end
  end

  assign rd_d = in_range ? mem[mem_idx] : '0;

  // Storage is deliberately outside the reset domain
  always_ff @(posedge Clock) begin
    if (mem_we) mem[mem_idx] <= DataOut;
    rd_q <= rd_d;
  end

endmodule

`default_nettype wire

// File: tb/tb_waitstate_data_mem.sv
// ----------------------------------------------------------------------------
// tb_waitstate_data_mem : scoreboard bench over four parameter variants
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_waitstate_data_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [11:0] addr [4];
  logic [15:0] dout [4];
  logic        wr   [4];
  logic        rd   [4];
  logic [15:0] din  [4];
  logic        wreq [4];

  typedef struct {
    int          stalls;
    logic [15:0] data;
    bit          chk;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // 0: defaults  1: WR_WAIT=0, DEPTH=3000  2: random MAX_WAIT=4  3: RD_WAIT=1, WR_WAIT=3
  waitstate_data_mem u_a (
    .Clock(clk), .Reset(rst), .DataAddr(addr[0]), .DataOut(dout[0]),
    .WriteData(wr[0]), .ReadData(rd[0]), .DataIn(din[0]), .DataWaitreq(wreq[0]));

  waitstate_data_mem #(.WR_WAIT(0), .DEPTH(3000)) u_b (
    .Clock(clk), .Reset(rst), .DataAddr(addr[1]), .DataOut(dout[1]),
    .WriteData(wr[1]), .ReadData(rd[1]), .DataIn(din[1]), .DataWaitreq(wreq[1]));

  waitstate_data_mem #(.RAND_MODE(1), .MAX_WAIT(4)) u_c (
    .Clock(clk), .Reset(rst), .DataAddr(addr[2]), .DataOut(dout[2]),
    .WriteData(wr[2]), .ReadData(rd[2]), .DataIn(din[2]), .DataWaitreq(wreq[2]));

  waitstate_data_mem #(.RD_WAIT(1), .WR_WAIT(3)) u_d (
    .Clock(clk), .Reset(rst), .DataAddr(addr[3]), .DataOut(dout[3]),
    .WriteData(wr[3]), .ReadData(rd[3]), .DataIn(din[3]), .DataWaitreq(wreq[3]));

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] pat(input int i);
    return 16'hC3A0 ^ (16'(i) * 16'h0111);
  endfunction

  task automatic txn(input int u, input bit w, input bit r, input logic [11:0] a,
                     input logic [15:0] d, output int stalls, output logic [15:0] q);
    @(negedge clk);
    wr[u] = w; rd[u] = r; addr[u] = a; dout[u] = d;
    #1;
    stalls = 0;
    while (wreq[u] === 1'b1 && stalls < 40) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    q = din[u];
  endtask

  task automatic go_idle(input int u);
    @(negedge clk);
    wr[u] = 1'b0; rd[u] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int u = 0; u < 4; u++) begin
      wr[u] = 1'b0; rd[u] = 1'b0; addr[u] = '0; dout[u] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int u = 0; u < 4; u++) begin
      n_vec++;
      if (wreq[u] !== 1'b0 || din[u] !== 16'h0000) begin
        n_bad++;
        $display("FAIL reset_state u%0d: waitreq=%b din=%h, required waitreq=0 din=0000", u, wreq[u], din[u]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fixed_read;
    int st; logic [15:0] q; exp_t e;
    sb.push_back('{1, 16'h0000, 1'b0});
    txn(0, 1'b1, 1'b0, 12'd5, 16'h1234, st, q);
    e = sb.pop_front();
    n_vec++;
    if (st !== e.stalls) begin
      n_bad++; $display("FAIL preload_wr stalls: got %0d, required %0d", st, e.stalls);
    end
    sb.push_back('{2, 16'h1234, 1'b1});
    txn(0, 1'b0, 1'b1, 12'd5, 16'h0000, st, q);
    e = sb.pop_front();
    n_vec++;
    if (st !== e.stalls || q !== e.data) begin
      n_bad++; $display("FAIL fixed_read: stalls=%0d data=%h, required stalls=%0d data=%h", st, q, e.stalls, e.data);
    end
    go_idle(0);
    #1;
    n_vec++;
    if (wreq[0] !== 1'b0 || din[0] !== 16'h1234) begin
      n_bad++; $display("FAIL read_hold: waitreq=%b din=%h, required waitreq=0 din=1234", wreq[0], din[0]);
    end
  endtask

  task automatic test_zero_wait_write;
    int st; logic [15:0] q; exp_t e;
    sb.push_back('{0, 16'h0000, 1'b0});
    sb.push_back('{2, 16'hBEEF, 1'b1});
    txn(1, 1'b1, 1'b0, 12'h0A0, 16'hBEEF, st, q);
    e = sb.pop_front();
    n_vec++;
    if (st !== e.stalls) begin
      n_bad++; $display("FAIL zero_wait_wr stalls: got %0d, required %0d", st, e.stalls);
    end
    txn(1, 1'b0, 1'b1, 12'h0A0, 16'h0000, st, q);
    e = sb.pop_front();
    n_vec++;
    if (st !== e.stalls || q !== e.data) begin
      n_bad++; $display("FAIL read_after_zw: stalls=%0d data=%h, required stalls=%0d data=%h", st, q, e.stalls, e.data);
    end
    go_idle(1);
  endtask

  task automatic test_simultaneous;
    int st; logic [15:0] q; exp_t e;
    // DataIn must not change on a write acknowledge
    sb.push_back('{1, 16'h1234, 1'b1});
    txn(0, 1'b1, 1'b1, 12'd3, 16'h00FF, st, q);
    e = sb.pop_front();
    n_vec++;
    if (st !== e.stalls || q !== e.data) begin
      n_bad++; $display("FAIL rw_as_write: stalls=%0d din=%h, required stalls=%0d din=%h", st, q, e.stalls, e.data);
    end
    sb.push_back('{2, 16'h00FF, 1'b1});
    txn(0, 1'b0, 1'b1, 12'd3, 16'h0000, st, q);
    e = sb.pop_front();
    n_vec++;
    if (st !== e.stalls || q !== e.data) begin
      n_bad++; $display("FAIL rw_readback: stalls=%0d data=%h, required stalls=%0d data=%h", st, q, e.stalls, e.data);
    end
    go_idle(0);
  endtask

  task automatic test_out_of_range;
    int st; logic [15:0] q; exp_t e;
    logic [11:0] a_seq [4] = '{12'd952, 12'd3000, 12'd3000, 12'd952};
    bit          w_seq [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] d_seq [4] = '{16'h1111, 16'h5555, 16'h0000, 16'h0000};
    sb.push_back('{0, 16'h0000, 1'b0});
    sb.push_back('{0, 16'h0000, 1'b0});
    sb.push_back('{2, 16'h0000, 1'b1});
    sb.push_back('{2, 16'h1111, 1'b1});
    for (int i = 0; i < 4; i++) begin
      txn(1, w_seq[i], !w_seq[i], a_seq[i], d_seq[i], st, q);
      e = sb.pop_front();
      n_vec++;
      if (st !== e.stalls || (e.chk && q !== e.data)) begin
        n_bad++; $display("FAIL out_of_range step%0d: stalls=%0d data=%h, required stalls=%0d data=%h", i, st, q, e.stalls, e.data);
      end
    end
    go_idle(1);
  endtask

  task automatic test_reset_mid;
    int st; logic [15:0] q; exp_t e;
    sb.push_back('{3, 16'h0000, 1'b0});
    sb.push_back('{1, 16'hAAAA, 1'b1});
    txn(3, 1'b1, 1'b0, 12'd7, 16'hAAAA, st, q);
    e = sb.pop_front();
    n_vec++;
    if (st !== e.stalls) begin
      n_bad++; $display("FAIL wr3_stalls: got %0d, required %0d", st, e.stalls);
    end
    txn(3, 1'b0, 1'b1, 12'd7, 16'h0000, st, q);
    e = sb.pop_front();
    n_vec++;
    if (st !== e.stalls || q !== e.data) begin
      n_bad++; $display("FAIL rd1_before_rst: stalls=%0d data=%h, required stalls=%0d data=%h", st, q, e.stalls, e.data);
    end
    @(negedge clk);
    wr[3] = 1'b1; rd[3] = 1'b0; addr[3] = 12'd7; dout[3] = 16'h5555;
    @(negedge clk);
    #1;
    n_vec++;
    if (wreq[3] !== 1'b1) begin
      n_bad++; $display("FAIL in_wait_stall: waitreq=%b, required 1", wreq[3]);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (wreq[3] !== 1'b0) begin
      n_bad++; $display("FAIL waitreq_forced: waitreq=%b, required 0", wreq[3]);
    end
    @(negedge clk);
    wr[3] = 1'b0;
    #1;
    n_vec++;
    if (wreq[3] !== 1'b0 || din[3] !== 16'h0000) begin
      n_bad++; $display("FAIL after_rst: waitreq=%b din=%h, required waitreq=0 din=0000", wreq[3], din[3]);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.push_back('{1, 16'hAAAA, 1'b1});
    txn(3, 1'b0, 1'b1, 12'd7, 16'h0000, st, q);
    e = sb.pop_front();
    n_vec++;
    if (st !== e.stalls || q !== e.data) begin
      n_bad++; $display("FAIL mem_kept: stalls=%0d data=%h, required stalls=%0d data=%h", st, q, e.stalls, e.data);
    end
    go_idle(3);
  endtask

  task automatic test_back_to_back_rand;
    int st; int n; logic [15:0] q; logic [15:0] lf; exp_t e;
    int run_a [50];
    lf = 16'hACE1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      n = int'(lf % 16'd4) + 1;
      lf = lfsr_next(lf);
      sb.push_back('{n, 16'h0000, 1'b0});
      txn(2, 1'b1, 1'b0, 12'(i), pat(i), st, q);
      e = sb.pop_front();
      n_vec++;
      if (st !== e.stalls) begin
        n_bad++; $display("FAIL rand_wr%0d stalls: got %0d, required %0d", i, st, e.stalls);
      end
    end
    for (int pass = 0; pass < 2; pass++) begin
      go_idle(2);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      lf = 16'hACE1;
      for (int i = 0; i < 50; i++) begin
        n = int'(lf % 16'd4) + 1;
        lf = lfsr_next(lf);
        sb.push_back('{n, pat(i), 1'b1});
        txn(2, 1'b0, 1'b1, 12'(i), 16'h0000, st, q);
        e = sb.pop_front();
        n_vec++;
        if (st < 1 || st > 4 || st !== e.stalls || q !== e.data) begin
          n_bad++; $display("FAIL rand_rd p%0d i%0d: stalls=%0d data=%h, required stalls=%0d data=%h", pass, i, st, q, e.stalls, e.data);
        end
        if (pass == 0) begin
          run_a[i] = st;
        end else begin
          n_vec++;
          if (st !== run_a[i]) begin
            n_bad++; $display("FAIL rand_repeat i%0d: stalls=%0d, required %0d", i, st, run_a[i]);
          end
        end
      end
    end
    go_idle(2);
  endtask

  initial begin
    test_reset();
    test_fixed_read();
    test_zero_wait_write();
    test_simultaneous();
    test_out_of_range();
    test_reset_mid();
    test_back_to_back_rand();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
